// File: rtl/mbscore_mem_resp_pkg.sv
// mbscore_mem_resp_pkg: shared constants and address checking for the memory responder
package mbscore_mem_resp_pkg;
  localparam logic [1:0] MEM_ST_IDLE = 2'd0;
  localparam logic [1:0] MEM_ST_WAIT = 2'd1;
  localparam logic [1:0] MEM_ST_RESP = 2'd2;
  localparam int MEM_BE_WIDTH = 4;
  localparam logic MEM_ERR_NONE = 1'b0;
  localparam logic MEM_ERR_ERR = 1'b1;
  function automatic logic addr_err(input logic [31:0] a, input int depth_log2);
    return ((a[1:0] != 2'b00) || ((a >> (depth_log2 + 2)) != 32'd0)) ? MEM_ERR_ERR : MEM_ERR_NONE;
  endfunction
endpackage

// File: rtl/mbscore_mem_resp_if.sv
// mbscore_mem_resp_if: request/response channels between the core and the memory responder
interface mbscore_mem_resp_if #(parameter int DATA_WIDTH = 32);
  import mbscore_mem_resp_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MEM_BE_WIDTH-1:0] req_be;
  logic resp_valid;
  logic resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mbscore_mem_array.sv
// mbscore_mem_array: word array with synchronous byte-enabled write and synchronous read
module mbscore_mem_array
  import mbscore_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [MEM_BE_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (we)
        for (int i = 0; i < MEM_BE_WIDTH; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/mbscore_mem_resp.sv
// mbscore_mem_resp: single-outstanding memory responder with wait states and error checking
module mbscore_mem_resp
  import mbscore_mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mbscore_mem_resp_if.slave bus,
  output logic              busy
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, arr_rdata;
  logic [MEM_BE_WIDTH-1:0] be_q, be_d;
  logic accept, enter_resp;
  always_comb begin
    accept = bus.req_valid && state_q == MEM_ST_IDLE;
    enter_resp = (accept && WAIT_CYCLES == 0) || (state_q == MEM_ST_WAIT && cnt_q == '0);
    state_d = enter_resp ? MEM_ST_RESP :
              accept ? MEM_ST_WAIT :
              (state_q == MEM_ST_RESP && bus.resp_ready) ? MEM_ST_IDLE : state_q;
    cnt_d = accept ? CNT_LOAD : (state_q == MEM_ST_WAIT && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    we_d = accept ? bus.req_we : we_q;
    err_d = accept ? addr_err(bus.req_addr, DEPTH_LOG2) : err_q;
    idx_d = accept ? bus.req_addr[DEPTH_LOG2+1:2] : idx_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    be_d = accept ? bus.req_be : be_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_ST_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      err_q <= MEM_ERR_NONE;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      err_q <= err_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
    end
  end
  mbscore_mem_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk(clk),
    .en(enter_resp && rst_n),
    .we(we_d && err_d == MEM_ERR_NONE),
    .idx(idx_d),
    .wdata(wdata_d),
    .be(be_d),
    .rdata(arr_rdata)
  );
  assign bus.req_ready = state_q == MEM_ST_IDLE;
  assign bus.resp_valid = state_q == MEM_ST_RESP;
  assign bus.resp_err = bus.resp_valid && err_q == MEM_ERR_ERR;
  assign bus.resp_rdata = (bus.resp_valid && !we_q && err_q == MEM_ERR_NONE) ? arr_rdata : '0;
  assign busy = state_q != MEM_ST_IDLE;
endmodule

// File: tb/tb_mbscore_mem_resp.sv
// tb_mbscore_mem_resp: vector, corner-case and randomized checks for WAIT_CYCLES=0 and 2 builds
module tb_mbscore_mem_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic rv [2], rwe [2], rr [2];
  logic [31:0] ra [2], rwd [2];
  logic [3:0] rbe [2];
  logic rdy [2], vld [2], er [2], bsy [2];
  logic [31:0] rd [2];
  mbscore_mem_resp_if bus [2] ();
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].req_valid = rv[g];
    assign bus[g].req_we = rwe[g];
    assign bus[g].req_addr = ra[g];
    assign bus[g].req_wdata = rwd[g];
    assign bus[g].req_be = rbe[g];
    assign bus[g].resp_ready = rr[g];
    assign rdy[g] = bus[g].req_ready;
    assign vld[g] = bus[g].resp_valid;
    assign rd[g] = bus[g].resp_rdata;
    assign er[g] = bus[g].resp_err;
    mbscore_mem_resp #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(g * 2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus[g]),
      .busy(bsy[g])
    );
  end
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mdl [2][1024];
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  vec_t tv [$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mdl_apply(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] xrd, output logic xer);
    logic [9:0] wi;
    xer = (a % 4 != 0) || (a >= 32'h1000);
    xrd = 32'h0;
    wi = a[11:2];
    if (!xer && w)
      for (int i = 0; i < 4; i++) if (be[i]) mdl[d][wi][8*i +: 8] = wd[8*i +: 8];
    if (!xer && !w) xrd = mdl[d][wi];
  endtask
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] grd, output logic ger);
    int lat;
    @(negedge clk);
    chk("req_ready before request", rdy[d], 1);
    rv[d] = 1'b1; rwe[d] = w; ra[d] = a; rwd[d] = wd; rbe[d] = be; rr[d] = 1'b1;
    @(negedge clk);
    rv[d] = 1'b0; rwe[d] = ~w; ra[d] = $urandom; rwd[d] = $urandom; rbe[d] = 4'hF;
    lat = 1;
    while (!vld[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(d == 0 ? "latency w0" : "latency w2", lat, d == 0 ? 1 : 3);
    grd = rd[d];
    ger = er[d];
    @(negedge clk);
    chk("valid/ready after response", {30'd0, vld[d], rdy[d]}, 32'd1);
  endtask
  task automatic run(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit use_tbl, input logic [31:0] trd, input logic ter);
    logic [31:0] grd, xrd;
    logic ger, xer;
    txn(d, w, a, wd, be, grd, ger);
    mdl_apply(d, w, a, wd, be, xrd, xer);
    if (use_tbl) begin
      xrd = trd;
      xer = ter;
    end
    chk(use_tbl ? "vector rdata" : "model rdata", grd, xrd);
    chk(use_tbl ? "vector err" : "model err", ger, xer);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [31:0] a, xrd;
    logic xer;
    logic [31:0] bb [3];
    bb[0] = 32'h0; bb[1] = 32'h4; bb[2] = 32'hFFC;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = 32'h0; rwd[d] = 32'h0; rbe[d] = 4'h0; rr[d] = 1'b1;
    end
    tv.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
    tv.push_back('{1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0});
    tv.push_back('{1'b1, 32'h14, 32'h12345678, 4'hF, 32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h14, 32'hAAAAAAAA, 4'h0, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h14, 32'h0, 4'h0, 32'h12345678, 1'b0});
    tv.push_back('{1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0});
    tv.push_back('{1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
    tv.push_back('{1'b0, 32'h80000010, 32'h0, 4'h0, 32'h0, 1'b1});
    tv.push_back('{1'b1, 32'h10, 32'h77000000, 4'b1000, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h7722BE44, 1'b0});
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", rdy[d], 1);
      chk("reset resp_valid", vld[d], 0);
      chk("reset resp_rdata", rd[d], 0);
      chk("reset resp_err", er[d], 0);
      chk("reset busy", bsy[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[i]) run(1, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, 1'b1, tv[i].rdata, tv[i].err);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 32'h10; rr[1] = 1'b0;
    @(negedge clk);
    rv[1] = 1'b0;
    lat = 1;
    while (!vld[1] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("backpressure latency", lat, 3);
    for (int i = 0; i < 6; i++) begin
      chk("hold resp_valid", vld[1], 1);
      chk("hold resp_rdata", rd[1], 32'h7722BE44);
      chk("hold req_ready", rdy[1], 0);
      chk("hold busy", bsy[1], 1);
      rv[1] = 1'b1; ra[1] = 32'h14;
      @(negedge clk);
    end
    rv[1] = 1'b0; rr[1] = 1'b1;
    @(negedge clk);
    chk("release resp_valid", vld[1], 0);
    chk("release req_ready", rdy[1], 1);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 32'h10; rwd[1] = 32'hCAFEF00D; rbe[1] = 4'hF;
    @(negedge clk);
    rv[1] = 1'b0;
    chk("wait busy", bsy[1], 1);
    chk("wait req_ready", rdy[1], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset req_ready", rdy[1], 1);
    chk("async reset busy", bsy[1], 0);
    chk("async reset resp_valid", vld[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h7722BE44, 1'b0);
    for (int i = 0; i < 8; i++) run(1, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 31));
      if (k < 7) a[1:0] = 2'b00;
      if (k == 9) a[$urandom_range(12, 31)] = 1'b1;
      run(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 3; i++) run(0, 1'b1, bb[i], $urandom, 4'hF, 1'b0, 32'h0, 1'b0);
    run(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    rr[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("b2b req_ready", rdy[0], 1);
      chk("b2b idle resp_valid", vld[0], 0);
      rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = bb[i];
      @(negedge clk);
      mdl_apply(0, 1'b0, bb[i], 32'h0, 4'h0, xrd, xer);
      chk("b2b resp_valid", vld[0], 1);
      chk("b2b rdata", rd[0], xrd);
      chk("b2b err", er[0], xer);
      @(negedge clk);
    end
    rv[0] = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
